// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: releases domain resets in index order behind a ready handshake,
// then serves soft/global re-reset requests. Define RST_SEQ_WDOG_EN for the ack-timeout watchdog.
module rst_seq_ctrl #(
    parameter int unsigned N_DOM    = 4,
    parameter int unsigned HOLD_CYC = 16,
    parameter int unsigned ACK_TMO  = 64,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             global_rst_req_i,
    input  logic [N_DOM-1:0] soft_rst_req_i,
    input  logic [N_DOM-1:0] dom_ready_ack_i,
    output logic [N_DOM-1:0] dom_rst_n_o,
    output logic             seq_busy_o,
    output logic             seq_done_o,
    output logic             err_timeout_o,
    output logic [2:0]       err_dom_o
);

    localparam int unsigned IDX_W   = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam int unsigned MAX_CYC = (HOLD_CYC > ACK_TMO) ? HOLD_CYC : ACK_TMO;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOM - 1);

    typedef enum logic [2:0] {
        ST_ASSERT_ALL = 3'd0,
        ST_WAIT_ACK   = 3'd1,
        ST_RUN        = 3'd2,
        ST_SOFT_HOLD  = 3'd3,
        ST_SOFT_ACK   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0] idx_q, idx_d, idx_nxt, sel;
    logic [N_DOM-1:0] pending_q, pending_d;
    logic [N_DOM-1:0] dom_rst_n_q, dom_rst_n_d;
    logic             seq_busy_q, seq_busy_d;
    logic             seq_done_q, seq_done_d;
    logic             tmo;
    logic             ack_go;

    // Saturating counter keeps long ack waits from wrapping back into range.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign idx_nxt = idx_q + IDX_W'(1);

    // Lowest-index pending soft request wins.
    always_comb begin
        sel = '0;
        for (int i = N_DOM - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel = IDX_W'(i);
            end
        end
    end

`ifdef RST_SEQ_WDOG_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TMO - 1);

    logic       err_timeout_q, err_timeout_d;
    logic [2:0] err_dom_q, err_dom_d;

    assign tmo = (cnt_q == TMO_LAST) && !dom_ready_ack_i[idx_q];

    always_comb begin
        err_timeout_d = err_timeout_q;
        err_dom_d     = err_dom_q;
        if (tmo && !global_rst_req_i &&
            (state_q == ST_WAIT_ACK || state_q == ST_SOFT_ACK)) begin
            err_timeout_d = 1'b1;
            err_dom_d     = 3'(idx_q);
        end
    end

    // Error flags survive global re-sequencing; only rst_n clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout_q <= 1'b0;
            err_dom_q     <= 3'd0;
        end else begin
            err_timeout_q <= err_timeout_d;
            err_dom_q     <= err_dom_d;
        end
    end

    assign err_timeout_o = err_timeout_q;
    assign err_dom_o     = err_dom_q;
`else
    assign tmo           = 1'b0;
    assign err_timeout_o = 1'b0;
    assign err_dom_o     = 3'd0;
`endif

    // A timeout is treated exactly like a late ack.
    assign ack_go = dom_ready_ack_i[idx_q] | tmo;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_inc;
        idx_d       = idx_q;
        dom_rst_n_d = dom_rst_n_q;
        pending_d   = pending_q | soft_rst_req_i;

        case (state_q)
            ST_ASSERT_ALL: begin
                dom_rst_n_d = '0;
                if (cnt_q == HOLD_LAST) begin
                    dom_rst_n_d = N_DOM'(1);
                    idx_d       = '0;
                    cnt_d       = '0;
                    state_d     = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_go) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        dom_rst_n_d[idx_nxt] = 1'b1;
                        idx_d                = idx_nxt;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (pending_q != '0) begin
                    pending_d[sel]   = soft_rst_req_i[sel];
                    dom_rst_n_d[sel] = 1'b0;
                    idx_d            = sel;
                    state_d          = ST_SOFT_HOLD;
                end
            end
            ST_SOFT_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    dom_rst_n_d[idx_q] = 1'b1;
                    cnt_d              = '0;
                    state_d            = ST_SOFT_ACK;
                end
            end
            ST_SOFT_ACK: begin
                if (ack_go) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                dom_rst_n_d = '0;
                cnt_d       = '0;
                idx_d       = '0;
                state_d     = ST_ASSERT_ALL;
            end
        endcase

        // Global request overrides everything and drops same-cycle soft requests.
        if (global_rst_req_i) begin
            state_d     = ST_ASSERT_ALL;
            cnt_d       = '0;
            idx_d       = '0;
            dom_rst_n_d = '0;
            pending_d   = '0;
        end

        seq_busy_d = (state_d != ST_RUN);
        seq_done_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ASSERT_ALL;
            cnt_q       <= '0;
            idx_q       <= '0;
            pending_q   <= '0;
            dom_rst_n_q <= '0;
            seq_busy_q  <= 1'b1;
            seq_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            dom_rst_n_q <= dom_rst_n_d;
            seq_busy_q  <= seq_busy_d;
            seq_done_q  <= seq_done_d;
        end
    end

    assign dom_rst_n_o = dom_rst_n_q;
    assign seq_busy_o  = seq_busy_q;
    assign seq_done_o  = seq_done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: expected output transitions are queued as stimulus is
// applied and matched against observed edges of dom_rst_n / seq_done.
module tb_rst_seq_ctrl;

    localparam int unsigned N    = 4;
    localparam int unsigned HOLD = 16;
    localparam int unsigned TMO  = 64;
`ifdef RST_SEQ_WDOG_EN
    localparam int WDOG = 1;
`else
    localparam int WDOG = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         global_rst_req;
    logic [N-1:0] soft_rst_req;
    logic [N-1:0] dom_ready_ack;
    logic [N-1:0] dom_rst_n;
    logic         seq_busy;
    logic         seq_done;
    logic         err_timeout;
    logic [2:0]   err_dom;

    int checks = 0;
    int errors = 0;
    int cyc;

    logic [N-1:0] ack_en;
    int           hi_cnt[N];

    typedef struct {
        string tag;
        int    dom;
        int    lvl;
        int    at;
    } ev_t;

    ev_t sb[$];

    rst_seq_ctrl #(
        .N_DOM   (N),
        .HOLD_CYC(HOLD),
        .ACK_TMO (TMO),
        .CNT_W   (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .global_rst_req_i(global_rst_req),
        .soft_rst_req_i  (soft_rst_req),
        .dom_ready_ack_i (dom_ready_ack),
        .dom_rst_n_o     (dom_rst_n),
        .seq_busy_o      (seq_busy),
        .seq_done_o      (seq_done),
        .err_timeout_o   (err_timeout),
        .err_dom_o       (err_dom)
    );

    always #25 clk = ~clk;

    // Edge number since the last rst_n release (first edge is 1).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Step one clock; domain model raises ack 3 cycles after its reset releases.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (dom_rst_n[i] === 1'b1) hi_cnt[i]++;
            else                       hi_cnt[i] = 0;
            dom_ready_ack[i] = ack_en[i] && (hi_cnt[i] >= 3);
        end
    endtask

    task automatic push(input string tag, input int dom, input int lvl, input int at);
        ev_t e;
        e.tag = tag; e.dom = dom; e.lvl = lvl; e.at = at;
        sb.push_back(e);
    endtask

    task automatic note_event(input int dom, input int lvl);
        ev_t e;
        if (sb.size() == 0) begin
            chk("spurious_event", 1000 * cyc + 10 * (dom + 1) + lvl, -1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_dom"}, dom, e.dom);
            chk({e.tag, "_lvl"}, lvl, e.lvl);
            chk({e.tag, "_edge"}, cyc, e.at);
        end
    endtask

    // Watch output transitions for up to max_cyc edges; domain index -1 means seq_done.
    task automatic watch(input int max_cyc, input bit stop_empty);
        logic [N-1:0] pd;
        logic         pdone;
        pd    = dom_rst_n;
        pdone = seq_done;
        for (int k = 0; k < max_cyc; k++) begin
            if (stop_empty && sb.size() == 0) break;
            tick();
            for (int i = 0; i < N; i++) begin
                if (dom_rst_n[i] !== pd[i]) note_event(i, int'(dom_rst_n[i]));
            end
            if (seq_done !== pdone) note_event(-1, int'(seq_done));
            pd    = dom_rst_n;
            pdone = seq_done;
        end
        chk("sb_drain", sb.size(), 0);
        sb.delete();
    endtask

    task automatic push_powerup(input string p, input int base);
        push({p, "_d0"}, 0, 1, base + 16);
        push({p, "_d1"}, 1, 1, base + 19);
        push({p, "_d2"}, 2, 1, base + 22);
        push({p, "_d3"}, 3, 1, base + 25);
        push({p, "_done"}, -1, 1, base + 28);
    endtask

    initial begin
        int b;
        rst_n          = 1'b0;
        global_rst_req = 1'b0;
        soft_rst_req   = '0;
        dom_ready_ack  = '0;
        ack_en         = '1;
        foreach (hi_cnt[i]) hi_cnt[i] = 0;

        repeat (3) tick();
        chk("rst_dom", dom_rst_n, 0);
        chk("rst_busy", seq_busy, 1);
        chk("rst_done", seq_done, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_err_dom", err_dom, 0);

        // Power-up sequencing
        @(negedge clk);
        rst_n = 1'b1;
        push_powerup("pu", 0);
        watch(40, 1);
        chk("pu_busy", seq_busy, 0);
        chk("pu_dom", dom_rst_n, 15);

        // Single soft reset of domain 2
        b = cyc;
        soft_rst_req = 4'b0100;
        tick();
        soft_rst_req = '0;
        push("s2_fall", 2, 0, b + 2);
        push("s2_busy", -1, 0, b + 2);
        push("s2_rise", 2, 1, b + 18);
        push("s2_run", -1, 1, b + 21);
        watch(40, 1);

        // Two soft requests in one cycle: 1 then 3, never overlapping
        b = cyc;
        soft_rst_req = 4'b1010;
        tick();
        soft_rst_req = '0;
        push("s13_f1", 1, 0, b + 2);
        push("s13_b1", -1, 0, b + 2);
        push("s13_r1", 1, 1, b + 18);
        push("s13_run1", -1, 1, b + 21);
        push("s13_f3", 3, 0, b + 22);
        push("s13_b3", -1, 0, b + 22);
        push("s13_r3", 3, 1, b + 38);
        push("s13_run3", -1, 1, b + 41);
        watch(60, 1);
        chk("s13_dom", dom_rst_n, 15);

        // Global from RUN, then park in WAIT_ACK(1) with ack[1] withheld
        b = cyc;
        global_rst_req = 1'b1;
        tick();
        global_rst_req = 1'b0;
        chk("g_run_dom", dom_rst_n, 0);
        chk("g_run_busy", seq_busy, 1);
        chk("g_run_done", seq_done, 0);
        ack_en = 4'b1101;
        push("g_d0", 0, 1, b + 17);
        push("g_d1", 1, 1, b + 20);
        watch(40, 1);
        watch(5, 0);
        chk("w1_dom", dom_rst_n, 4'b0011);

        // Global abort during WAIT_ACK(1): full hold, restart from domain 0
        b = cyc;
        global_rst_req = 1'b1;
        tick();
        global_rst_req = 1'b0;
        chk("abort_dom", dom_rst_n, 0);
        chk("abort_busy", seq_busy, 1);
        push("ab_d0", 0, 1, b + 17);
        push("ab_d1", 1, 1, b + 20);
        watch(40, 1);

`ifdef RST_SEQ_WDOG_EN
        b = cyc;
        push("wd_d2", 2, 1, b + 64);
        push("wd_d3", 3, 1, b + 67);
        push("wd_done", -1, 1, b + 70);
        watch(100, 1);
        chk("wd_err", err_timeout, 1);
        chk("wd_err_dom", err_dom, 1);
        ack_en = '1;
`else
        watch(80, 0);
        chk("nowd_dom", dom_rst_n, 4'b0011);
        chk("nowd_busy", seq_busy, 1);
        chk("nowd_err", err_timeout, 0);
        chk("nowd_err_dom", err_dom, 0);
        b = cyc;
        ack_en = '1;
        push("nowd_d2", 2, 1, b + 2);
        push("nowd_d3", 3, 1, b + 5);
        push("nowd_done", -1, 1, b + 8);
        watch(20, 1);
`endif

        // Simultaneous global and soft: soft bits are dropped
        b = cyc;
        global_rst_req = 1'b1;
        soft_rst_req   = 4'b0001;
        tick();
        global_rst_req = 1'b0;
        soft_rst_req   = '0;
        chk("gs_dom", dom_rst_n, 0);
        push_powerup("gs", b + 1);
        watch(40, 1);
        watch(10, 0);
        chk("gs_err_keep", err_timeout, WDOG);
        chk("gs_err_dom_keep", err_dom, WDOG);

        // Async reset mid SOFT_HOLD with another request pending
        soft_rst_req = 4'b0100;
        tick();
        soft_rst_req = '0;
        tick();
        chk("ar_hold_dom", dom_rst_n, 4'b1011);
        chk("ar_hold_busy", seq_busy, 1);
        soft_rst_req = 4'b0001;
        tick();
        soft_rst_req = '0;
        tick();
        tick();
        #5;
        rst_n = 1'b0;
        #1;
        chk("ar_dom", dom_rst_n, 0);
        chk("ar_busy", seq_busy, 1);
        chk("ar_done", seq_done, 0);
        chk("ar_err", err_timeout, 0);
        chk("ar_err_dom", err_dom, 0);
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        push_powerup("ar_pu", 0);
        watch(40, 1);
        watch(20, 0);
        chk("ar_final_dom", dom_rst_n, 15);
        chk("ar_final_done", seq_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
